tap_controller: RTL and testbench



---
 rtl/tap_pkg.sv | 39 +++
 rtl/tap_fsm.sv | 51 +++++
 rtl/tap_controller.sv | 126 ++++++++++++
 tb/tb_tap_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared types for the JTAG TAP: the 16-state FSM encoding, instruction
// opcodes and the data-register select used by the scan-path decode.
package tap_pkg;

  // IEEE 1149.1 reference encoding, so state_o matches common debug tooling.
  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_EXTEST         = 4'h0;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] OP_IDCODE         = 4'h2;
  localparam logic [3:0] OP_BYPASS         = 4'hF;

  // Length of the external boundary chain; the TAP itself never stores it.
  localparam int BS_LEN = 32;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_BOUNDARY
  } dr_sel_e;

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: state register plus TMS-driven next-state decode.
// The next state is exported so the owner can act on entry to a state.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output tap_state_e state_nxt_o
);

  tap_state_e state;
  tap_state_e state_nxt;

  always_ff @(posedge tck_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst_i) state <= TLR;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = TLR;
    case (state)
      TLR:     state_nxt = tms_i ? TLR    : RTI;
      RTI:     state_nxt = tms_i ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms_i ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms_i ? UPD_DR : PA_DR;
      PA_DR:   state_nxt = tms_i ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms_i ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms_i ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms_i ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms_i ? UPD_IR : PA_IR;
      PA_IR:   state_nxt = tms_i ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms_i ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  assign state_o     = state;
  assign state_nxt_o = state_nxt;

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: owns IR, bypass and IDCODE registers, drives the
// boundary-cell control strobes and the falling-edge TDO stage.
module tap_controller
  import tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0C4D
) (
  input  logic            tck_i,
  input  logic            rst_i,
  input  logic            tms_i,
  input  logic            tdi_i,
  input  logic            bs_so_i,
  output logic            tdo_o,
  output logic            tdo_en_o,
  output logic            clock_dr_o,
  output logic            shift_dr_o,
  output logic            update_dr_o,
  output logic            mode_o,
  output logic [3:0]      state_o,
  output logic [IR_W-1:0] ir_o
);

  // The IDCODE marker bit is forced so a bad override cannot hide the device.
  localparam logic [31:0] IDCODE_W = {IDCODE_VAL[31:1], 1'b1};

  tap_state_e      state;
  tap_state_e      state_nxt;
  dr_sel_e         dr_sel;
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] ir_sr;
  logic [31:0]     idcode_sr;
  logic            bypass_sr;

  logic cdr_en_d, udr_en_d, shift_dr_d, tdo_en_d, tdo_d;
  logic cdr_en, udr_en, shift_dr_q, tdo_en_q, tdo_q;

  tap_fsm u_fsm (
    .tck_i       (tck_i),
    .rst_i       (rst_i),
    .tms_i       (tms_i),
    .state_o     (state),
    .state_nxt_o (state_nxt)
  );

  // Unknown opcodes fall through to BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == IR_W'(OP_EXTEST) || ir_q == IR_W'(OP_SAMPLE_PRELOAD))
      dr_sel = DR_BOUNDARY;
    else if (ir_q == IR_W'(OP_IDCODE))
      dr_sel = DR_IDCODE;
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      ir_sr <= '0;
      ir_q  <= IR_W'(OP_IDCODE);
    end else begin
      if (state == CAP_IR)     ir_sr <= IR_W'(2'b01);
      else if (state == SH_IR) ir_sr <= {tdi_i, ir_sr[IR_W-1:1]};

      if (state_nxt == TLR)     ir_q <= IR_W'(OP_IDCODE);
      else if (state == UPD_IR) ir_q <= ir_sr;
    end
  end

  // Only the selected data register captures or shifts.
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
    end else if (state == CAP_DR) begin
      if (dr_sel == DR_IDCODE) idcode_sr <= IDCODE_W;
      if (dr_sel == DR_BYPASS) bypass_sr <= 1'b0;
    end else if (state == SH_DR) begin
      if (dr_sel == DR_IDCODE) idcode_sr <= {tdi_i, idcode_sr[31:1]};
      if (dr_sel == DR_BYPASS) bypass_sr <= tdi_i;
    end
  end

  always_comb begin
    cdr_en_d   = (dr_sel == DR_BOUNDARY) && (state == CAP_DR || state == SH_DR);
    udr_en_d   = (dr_sel == DR_BOUNDARY) && (state == UPD_DR);
    shift_dr_d = (state == SH_DR);
    tdo_en_d   = (state == SH_DR) || (state == SH_IR);
    tdo_d      = 1'b0;
    if (state == SH_IR) begin
      tdo_d = ir_sr[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_IDCODE:   tdo_d = idcode_sr[0];
        DR_BOUNDARY: tdo_d = bs_so_i;
        default:     tdo_d = bypass_sr;
      endcase
    end
  end

  // Falling-edge stage: the enables settle while tck_i is low, so the
  // AND-gated strobes below cannot glitch.
  always_ff @(negedge tck_i) begin
    if (rst_i) begin
      cdr_en     <= 1'b0;
      udr_en     <= 1'b0;
      shift_dr_q <= 1'b0;
      tdo_en_q   <= 1'b0;
      tdo_q      <= 1'b0;
    end else begin
      cdr_en     <= cdr_en_d;
      udr_en     <= udr_en_d;
      shift_dr_q <= shift_dr_d;
      tdo_en_q   <= tdo_en_d;
      tdo_q      <= tdo_d;
    end
  end

  assign clock_dr_o  = tck_i & cdr_en;
  assign update_dr_o = tck_i & udr_en;
  assign shift_dr_o  = shift_dr_q;
  assign tdo_en_o    = tdo_en_q;
  assign tdo_o       = tdo_q;
  assign mode_o      = (ir_q == IR_W'(OP_EXTEST));
  assign state_o     = state;
  assign ir_o        = ir_q;

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: state-walk vector table, directed scan sequences
// and a random TMS walk, all checked against a queue-based TAP model.
module tb_tap_controller;
  import tap_pkg::*;

  logic       tck_i = 1'b0;
  logic       rst_i, tms_i, tdi_i, bs_so_i;
  logic       tdo_o, tdo_en_o, clock_dr_o, shift_dr_o, update_dr_o, mode_o;
  logic [3:0] state_o;
  logic [3:0] ir_o;

  tap_controller dut (
    .tck_i       (tck_i),
    .rst_i       (rst_i),
    .tms_i       (tms_i),
    .tdi_i       (tdi_i),
    .bs_so_i     (bs_so_i),
    .tdo_o       (tdo_o),
    .tdo_en_o    (tdo_en_o),
    .clock_dr_o  (clock_dr_o),
    .shift_dr_o  (shift_dr_o),
    .update_dr_o (update_dr_o),
    .mode_o      (mode_o),
    .state_o     (state_o),
    .ir_o        (ir_o)
  );

  always #5 tck_i = ~tck_i;

  localparam logic [31:0] IDCODE_EXP = 32'h1000_0C4D;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobe edge counters: observed from the DUT, expected from the model.
  int cdr_seen = 0, udr_seen = 0, cdr_exp = 0, udr_exp = 0;
  int base_cs, base_us, base_ce, base_ue;
  always @(posedge clock_dr_o)  cdr_seen++;
  always @(posedge update_dr_o) udr_seen++;

  task automatic mark();
    base_cs = cdr_seen; base_us = udr_seen;
    base_ce = cdr_exp;  base_ue = udr_exp;
  endtask

  // Reference model: transition table plus bit queues (front = next bit out).
  tap_state_e nxt0[16];
  tap_state_e nxt1[16];
  tap_state_e m_state = TLR;
  logic [3:0] m_ir = 4'h2;
  bit         m_irq[$];
  bit         m_drq[$];

  task automatic set_t(input tap_state_e s, input tap_state_e on0, input tap_state_e on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  function automatic bit is_bnd(input logic [3:0] ir);
    return ir == 4'h0 || ir == 4'h1;
  endfunction

  task automatic model_edge(input logic rst, input logic tms, input logic tdi);
    tap_state_e s = m_state;
    if (is_bnd(m_ir) && (s == CAP_DR || s == SH_DR)) cdr_exp++;
    if (is_bnd(m_ir) && s == UPD_DR) udr_exp++;
    if (rst) begin
      m_state = TLR;
      m_ir    = 4'h2;
      m_irq.delete();
      m_drq.delete();
      return;
    end
    case (s)
      CAP_IR: m_irq = '{1'b1, 1'b0, 1'b0, 1'b0};
      SH_IR:  begin void'(m_irq.pop_front()); m_irq.push_back(tdi); end
      UPD_IR: m_ir = {m_irq[3], m_irq[2], m_irq[1], m_irq[0]};
      CAP_DR: begin
        if (m_ir == 4'h2) begin
          m_drq.delete();
          for (int i = 0; i < 32; i++) m_drq.push_back(IDCODE_EXP[i]);
        end else if (!is_bnd(m_ir)) begin
          m_drq = '{1'b0};
        end
      end
      SH_DR: if (!is_bnd(m_ir)) begin void'(m_drq.pop_front()); m_drq.push_back(tdi); end
      default: ;
    endcase
    m_state = tms ? nxt1[s] : nxt0[s];
    if (m_state == TLR) m_ir = 4'h2;
  endtask

  task automatic compare_all();
    logic exp_tdo = 1'b0;
    if (m_state == SH_IR)      exp_tdo = m_irq[0];
    else if (m_state == SH_DR) exp_tdo = is_bnd(m_ir) ? bs_so_i : m_drq[0];
    check("state",    32'(state_o),    32'(m_state));
    check("ir",       32'(ir_o),       32'(m_ir));
    check("mode",     32'(mode_o),     32'(m_ir == 4'h0));
    check("shift_dr", 32'(shift_dr_o), 32'(m_state == SH_DR));
    check("tdo_en",   32'(tdo_en_o),   32'(m_state == SH_DR || m_state == SH_IR));
    check("tdo",      32'(tdo_o),      32'(exp_tdo));
  endtask

  // One TCK cycle: drive after the falling edge, check after the next one.
  task automatic step(input logic tms, input logic tdi, input logic rst = 1'b0);
    tms_i   = tms;
    tdi_i   = tdi;
    rst_i   = rst;
    bs_so_i = 1'($urandom_range(0, 1));
    @(posedge tck_i);
    model_edge(rst, tms, tdi);
    @(negedge tck_i);
    #1;
    compare_all();
  endtask

  // Full scan from RTI back to RTI; dout collects TDO LSB-first.
  task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                      output logic [31:0] dout);
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo_o;
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic       tms;
    tap_state_e st;
    logic [3:0] ir;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rst, input logic tms, input tap_state_e st, input logic [3:0] ir);
    vec_t v;
    v.rst = rst; v.tms = tms; v.st = st; v.ir = ir;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rb;
    rst_i = 1'b1; tms_i = 1'b0; tdi_i = 1'b0; bs_so_i = 1'b0;

    set_t(TLR, RTI, TLR);       set_t(RTI, RTI, SEL_DR);
    set_t(SEL_DR, CAP_DR, SEL_IR); set_t(CAP_DR, SH_DR, EX1_DR);
    set_t(SH_DR, SH_DR, EX1_DR);  set_t(EX1_DR, PA_DR, UPD_DR);
    set_t(PA_DR, PA_DR, EX2_DR);  set_t(EX2_DR, SH_DR, UPD_DR);
    set_t(UPD_DR, RTI, SEL_DR);   set_t(SEL_IR, CAP_IR, TLR);
    set_t(CAP_IR, SH_IR, EX1_IR); set_t(SH_IR, SH_IR, EX1_IR);
    set_t(EX1_IR, PA_IR, UPD_IR); set_t(PA_IR, PA_IR, EX2_IR);
    set_t(EX2_IR, SH_IR, UPD_IR); set_t(UPD_IR, RTI, SEL_DR);

    // Walk every state; the bare IR capture 4'b0001 lands as SAMPLE_PRELOAD,
    // and entering TLR restores IDCODE on the same edge.
    add(1, 0, TLR, 4'h2);    add(0, 0, RTI, 4'h2);    add(0, 1, SEL_DR, 4'h2);
    add(0, 0, CAP_DR, 4'h2); add(0, 0, SH_DR, 4'h2);  add(0, 1, EX1_DR, 4'h2);
    add(0, 0, PA_DR, 4'h2);  add(0, 0, PA_DR, 4'h2);  add(0, 1, EX2_DR, 4'h2);
    add(0, 0, SH_DR, 4'h2);  add(0, 1, EX1_DR, 4'h2); add(0, 1, UPD_DR, 4'h2);
    add(0, 1, SEL_DR, 4'h2); add(0, 1, SEL_IR, 4'h2); add(0, 0, CAP_IR, 4'h2);
    add(0, 1, EX1_IR, 4'h2); add(0, 0, PA_IR, 4'h2);  add(0, 1, EX2_IR, 4'h2);
    add(0, 1, UPD_IR, 4'h2); add(0, 0, RTI, 4'h1);    add(0, 1, SEL_DR, 4'h1);
    add(0, 1, SEL_IR, 4'h1); add(0, 1, TLR, 4'h2);    add(0, 1, TLR, 4'h2);
    add(0, 0, RTI, 4'h2);

    foreach (vq[i]) begin
      step(vq[i].tms, 1'($urandom_range(0, 1)), vq[i].rst);
      check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vq[i].st));
      check($sformatf("vec%0d_ir", i),    32'(ir_o),    32'(vq[i].ir));
    end

    // Five TMS-high edges from inside Shift-DR reach TLR.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
    check("tms5_tlr", 32'(state_o), 32'(TLR));
    step(1'b0, 1'b0);

    scan(1'b0, 32, $urandom, d);
    check("idcode_stream", d, IDCODE_EXP);

    scan(1'b1, 4, 32'hF, d);
    check("ir_capture_bits", 32'(d[1:0]), 32'h1);
    check("ir_bypass", 32'(ir_o), 32'hF);
    scan(1'b0, 8, 32'hB2, d);
    check("bypass_echo", 32'(d[7:0]), 32'h64);

    scan(1'b1, 4, 32'h1, d);
    mark();
    scan(1'b0, BS_LEN, $urandom, d);
    check("sample_cdr_edges", 32'(cdr_seen - base_cs), 32'd33);
    check("sample_udr_edges", 32'(udr_seen - base_us), 32'd1);
    check("sample_mode", 32'(mode_o), 32'd0);

    scan(1'b1, 4, 32'h0, d);
    check("extest_mode", 32'(mode_o), 32'd1);
    scan(1'b1, 4, 32'h7, d);
    check("op7_mode", 32'(mode_o), 32'd0);
    rb = 8'($urandom);
    scan(1'b0, 8, 32'(rb), d);
    check("op7_bypass_echo", 32'(d[7:0]), 32'({rb[6:0], 1'b0}));

    // Reset in the middle of an EXTEST boundary shift.
    scan(1'b1, 4, 32'h0, d);
    mark();
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b1);
    check("rst_state", 32'(state_o), 32'(TLR));
    check("rst_ir", 32'(ir_o), 32'h2);
    check("rst_mode", 32'(mode_o), 32'd0);
    check("rst_udr_edges", 32'(udr_seen - base_us), 32'd0);
    check("rst_cdr_edges", 32'(cdr_seen - base_cs), 32'd7);
    step(1'b0, 1'b0);

    mark();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) == 0));
    check("rand_cdr_edges", 32'(cdr_seen - base_cs), 32'(cdr_exp - base_ce));
    check("rand_udr_edges", 32'(udr_seen - base_us), 32'(udr_exp - base_ue));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
